// File: rtl/uart_line_echo.sv
// Line-at-a-time UART echo: buffers received bytes until CR/LF, then replays line + terminator.
// Define UART_LINE_ECHO_BACKSPACE_EN to make 0x08/0x7F delete the last stored byte.
module uart_line_echo #(
    parameter int unsigned  DEPTH  = 64,
    parameter logic [7:0]   TERM_A = 8'h0D,
    parameter logic [7:0]   TERM_B = 8'h0A,
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] line_len,
    output logic          overflow,
    output logic          busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] StFill  = 1'b0;
    localparam logic [0:0] StDrain = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    term_q, term_d;
    logic          overflow_q, overflow_d;
    logic          wr_en;
    logic          in_fire, out_fire, is_term, is_bs, has_data;
    logic [7:0]    mem_q [DEPTH];

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign is_term  = (in_data == TERM_A) || (in_data == TERM_B);
    assign has_data = rd_ptr_q < count_q;

`ifdef UART_LINE_ECHO_BACKSPACE_EN
    assign is_bs = (in_data == 8'h08) || (in_data == 8'h7F);
`else
    assign is_bs = 1'b0;
`endif

    assign in_ready  = (state_q == StFill);
    assign busy      = (state_q == StDrain);
    assign out_valid = busy;
    assign out_data  = has_data ? mem_q[rd_ptr_q[AW-1:0]] : term_q;
    assign line_len  = count_q;
    assign overflow  = overflow_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        term_d     = term_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        case (state_q)
            StFill: begin
                if (in_fire) begin
                    if (is_term) begin
                        term_d   = in_data;
                        rd_ptr_d = '0;
                        state_d  = StDrain;
                    end else if (is_bs) begin
                        if (count_q != '0) count_d = count_q - CW'(1);
                    end else if (count_q < CW'(DEPTH)) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_fire) begin
                    if (has_data) begin
                        rd_ptr_d = rd_ptr_q + CW'(1);
                    end else begin
                        // Terminator just left: start a fresh line.
                        state_d    = StFill;
                        count_d    = '0;
                        rd_ptr_d   = '0;
                        overflow_d = 1'b0;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StFill;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            term_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            term_q     <= term_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer storage is not reset; count_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[count_q[AW-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_uart_line_echo.sv
// Self-checking bench for uart_line_echo (DEPTH=4) with a byte-stream scoreboard.
module tb_uart_line_echo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] line_len;
    logic          overflow;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] line_q[$];

    int         ready_mode = 0;  // 0: stall, 1: always ready, 2: pattern 1,0,0,1
    logic [3:0] ready_pat  = 4'b1001;
    int         pat_idx    = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    uart_line_echo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .line_len  (line_len),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: begin
                out_ready = ready_pat[pat_idx];
                pat_idx   = (pat_idx + 1) % 4;
            end
        endcase
    end

    // Output monitor: handshakes resolve at the following posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", {31'b0, out_valid}, 32'd1);
                check_eq("hold_data", {24'b0, out_data}, {24'b0, prev_data});
            end
            if (out_valid) check_eq("in_ready_drain", {31'b0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("out_unexpected", {24'b0, out_data}, 32'hFFFF_FFFF);
                else check_eq("out_data", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic model_accept(input logic [7:0] b);
        if (b == 8'h0D || b == 8'h0A) begin
            foreach (line_q[i]) exp_q.push_back(line_q[i]);
            exp_q.push_back(b);
            line_q.delete();
`ifdef UART_LINE_ECHO_BACKSPACE_EN
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (line_q.size() > 0) void'(line_q.pop_back());
`endif
        end else if (line_q.size() < DEPTH) begin
            line_q.push_back(b);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("in_ready_timeout", {31'b0, in_ready}, 32'd1);
        end else begin
            check_eq("fill_out_valid", {31'b0, out_valid}, 32'd0);
            model_accept(b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, exp_q.size(), 32'd0);
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_line_len", {29'b0, line_len}, 32'd0);
        check_eq("rst_overflow", {31'b0, overflow}, 32'd0);
        rst_n      = 1'b1;
        ready_mode = 1;

        // "ABC\r": drains in 4 consecutive cycles starting the cycle after the CR.
        send_byte("A");
        send_byte("B");
        send_byte("C");
        send_byte(8'h0D);
        check_eq("abc_valid_latency", {31'b0, out_valid}, 32'd1);
        check_eq("abc_line_len", {29'b0, line_len}, 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abc_busy_last", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("abc_drained", exp_q.size(), 32'd0);
        check_eq("abc_busy_done", {31'b0, busy}, 32'd0);
        check_eq("abc_len_done", {29'b0, line_len}, 32'd0);

        // Lone LF: empty line, single output byte.
        send_byte(8'h0A);
        check_eq("lf_busy", {31'b0, busy}, 32'd1);
        check_eq("lf_len", {29'b0, line_len}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("lf_busy_done", {31'b0, busy}, 32'd0);
        check_eq("lf_drained", exp_q.size(), 32'd0);

        // Overflow: '1'..'6' into DEPTH=4.
        for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
        check_eq("ovf_before", {31'b0, overflow}, 32'd0);
        send_byte("5");
        check_eq("ovf_set", {31'b0, overflow}, 32'd1);
        send_byte("6");
        check_eq("ovf_len", {29'b0, line_len}, 32'd4);
        send_byte(8'h0D);
        check_eq("ovf_drain", {31'b0, overflow}, 32'd1);
        wait_idle("ovf_idle");
        check_eq("ovf_cleared", {31'b0, overflow}, 32'd0);

        // "hi\r" under a stalling transmitter; 'x' offered during drain.
        ready_mode = 2;
        send_byte("h");
        send_byte("i");
        send_byte(8'h0D);
        send_byte("x");
        check_eq("x_after_drain", exp_q.size(), 32'd0);
        check_eq("x_len", {29'b0, line_len}, 32'd1);
        send_byte(8'h0D);
        wait_idle("stall_idle");

        // Reset mid-drain discards the line.
        ready_mode = 0;
        send_byte("a");
        send_byte("b");
        send_byte("c");
        send_byte("d");
        send_byte(8'h0D);
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("mid_rst_len", {29'b0, line_len}, 32'd0);
        check_eq("mid_rst_ovf", {31'b0, overflow}, 32'd0);
        exp_q.delete();
        rst_n      = 1'b1;
        ready_mode = 1;
        send_byte("z");
        send_byte(8'h0D);
        wait_idle("post_rst_idle");

        // DEL handling: edit in backspace build, ordinary byte otherwise.
        send_byte("a");
        send_byte("b");
        send_byte(8'h7F);
        send_byte("c");
`ifdef UART_LINE_ECHO_BACKSPACE_EN
        check_eq("bs_len", {29'b0, line_len}, 32'd2);
`else
        check_eq("bs_len", {29'b0, line_len}, 32'd4);
`endif
        send_byte(8'h0D);
        wait_idle("bs_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
